// File: rtl/intc_route_ctrl_pkg.sv
// intc_route_ctrl_pkg: shared types and constants for the interconnect route controller.
package intc_route_ctrl_pkg;
  localparam int ROUTE_LAT = 2;
  localparam int IDX_W = 5;
  localparam int CMD_LEN_W = 16;
  typedef enum logic [1:0] {R_IDLE, R_ACTIVE, R_DRAIN} route_state_t;
  typedef struct packed {
    logic dir;
    logic [IDX_W-1:0] src;
    logic [IDX_W-1:0] dst;
    logic [CMD_LEN_W-1:0] len;
  } route_cmd_t;
endpackage

// File: rtl/intc_route_fsm.sv
// intc_route_fsm: per-destination route FSM holding a select for len beats, then draining the interconnect pipeline.
module intc_route_fsm
  import intc_route_ctrl_pkg::*;
#(
  parameter int SEL_W = 5,
  parameter int NULL_CODE = 20,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SEL_W-1:0] src,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             done
);
  route_state_t state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic done_q, done_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    done_d = 1'b0;
    case (state_q)
      R_IDLE: if (load) begin
        state_d = R_ACTIVE;
        cnt_d = len;
        sel_d = src;
      end
      R_ACTIVE: if (abort || cnt_q == LEN_W'(1)) begin
        state_d = R_DRAIN;
        cnt_d = LEN_W'(ROUTE_LAT);
        sel_d = SEL_W'(NULL_CODE);
      end else cnt_d = cnt_q - LEN_W'(1);
      R_DRAIN: if (cnt_q == LEN_W'(1)) begin
        state_d = R_IDLE;
        cnt_d = '0;
        done_d = 1'b1;
      end else cnt_d = cnt_q - LEN_W'(1);
      default: state_d = R_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= R_IDLE;
      cnt_q <= '0;
      sel_q <= SEL_W'(NULL_CODE);
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      done_q <= done_d;
    end
  end
  assign sel = sel_q;
  assign busy = state_q != R_IDLE;
  assign done = done_q;
endmodule

// File: rtl/intc_route_ctrl.sv
// intc_route_ctrl: decodes scheduler route commands into per-slot and per-module select FSMs.
module intc_route_ctrl
  import intc_route_ctrl_pkg::*;
#(
  parameter int SLOT_NUM = 20,
  parameter int MODULE_NUM = 20,
  parameter int LEN_W = 16,
  localparam int MS_W = $clog2(MODULE_NUM),
  localparam int SS_W = $clog2(SLOT_NUM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_dir,
  input  logic [IDX_W-1:0]               cmd_src,
  input  logic [IDX_W-1:0]               cmd_dst,
  input  logic [LEN_W-1:0]               cmd_len,
  input  logic                           abort_valid,
  input  logic                           abort_dir,
  input  logic [IDX_W-1:0]               abort_dst,
  output logic [SLOT_NUM-1:0][MS_W-1:0]  module_select,
  output logic [MODULE_NUM-1:0][SS_W-1:0] slot_select,
  output logic [SLOT_NUM-1:0]            slot_busy,
  output logic [MODULE_NUM-1:0]          module_busy,
  output logic [SLOT_NUM-1:0]            slot_done,
  output logic [MODULE_NUM-1:0]          module_done,
  output logic                           cmd_err
);
  logic legal, abort_hit, dst_busy, accept, err_q, err_d;
  logic [31:0] slot_busy_x, module_busy_x;
  assign slot_busy_x = 32'(slot_busy);
  assign module_busy_x = 32'(module_busy);
  always_comb begin
    legal = cmd_len != '0 && (cmd_dir ? (int'(cmd_dst) < MODULE_NUM && int'(cmd_src) < SLOT_NUM)
                                      : (int'(cmd_dst) < SLOT_NUM && int'(cmd_src) < MODULE_NUM));
    abort_hit = abort_valid && abort_dir == cmd_dir && abort_dst == cmd_dst;
    dst_busy = cmd_dir ? module_busy_x[cmd_dst] : slot_busy_x[cmd_dst];
    // Illegal commands are always ready so they drain and only raise cmd_err.
    cmd_ready = !legal || (!dst_busy && !abort_hit);
    accept = cmd_valid && cmd_ready;
    err_d = accept && !legal;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign cmd_err = err_q;
  for (genvar i = 0; i < SLOT_NUM; i++) begin : g_slot
    intc_route_fsm #(.SEL_W(MS_W), .NULL_CODE(MODULE_NUM), .LEN_W(LEN_W)) u_fsm (
      .clk, .rst,
      .load(accept && legal && !cmd_dir && cmd_dst == IDX_W'(i)),
      .src(MS_W'(cmd_src)),
      .len(cmd_len),
      .abort(abort_valid && !abort_dir && abort_dst == IDX_W'(i)),
      .sel(module_select[i]),
      .busy(slot_busy[i]),
      .done(slot_done[i])
    );
  end
  for (genvar i = 0; i < MODULE_NUM; i++) begin : g_mod
    intc_route_fsm #(.SEL_W(SS_W), .NULL_CODE(SLOT_NUM), .LEN_W(LEN_W)) u_fsm (
      .clk, .rst,
      .load(accept && legal && cmd_dir && cmd_dst == IDX_W'(i)),
      .src(SS_W'(cmd_src)),
      .len(cmd_len),
      .abort(abort_valid && abort_dir && abort_dst == IDX_W'(i)),
      .sel(slot_select[i]),
      .busy(module_busy[i]),
      .done(module_done[i])
    );
  end
endmodule

// File: tb/tb_intc_route_ctrl.sv
// tb_intc_route_ctrl: directed checks of route timing, illegal commands, abort, broadcast and reset.
module tb_intc_route_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_dir = 1'b0;
  logic [4:0] cmd_src = '0, cmd_dst = '0;
  logic [15:0] cmd_len = '0;
  logic abort_valid = 1'b0, abort_dir = 1'b0;
  logic [4:0] abort_dst = '0;
  logic [19:0][4:0] module_select, slot_select;
  logic [19:0] slot_busy, module_busy, slot_done, module_done;
  logic cmd_err;
  logic [99:0] null_v;
  int errors = 0;
  int checks = 0;

  intc_route_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .abort_valid(abort_valid),
    .abort_dir(abort_dir), .abort_dst(abort_dst), .module_select(module_select),
    .slot_select(slot_select), .slot_busy(slot_busy), .module_busy(module_busy),
    .slot_done(slot_done), .module_done(module_done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic send(input logic d, input logic [4:0] s, input logic [4:0] t, input logic [15:0] l);
    cmd_valid = 1'b1;
    cmd_dir = d;
    cmd_src = s;
    cmd_dst = t;
    cmd_len = l;
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
    abort_valid = 1'b0;
  endtask

  initial begin
    null_v = {20{5'd20}};
    nxt(); nxt();
    chk("rst_ms", module_select, null_v);
    chk("rst_ss", slot_select, null_v);
    chk("rst_sbusy", slot_busy, 0);
    chk("rst_mbusy", module_busy, 0);
    chk("rst_done", {slot_done, module_done}, 0);
    chk("rst_err", cmd_err, 0);
    // write route, accepted on the first cycle after reset release
    rst = 1'b0;
    send(0, 7, 3, 4);
    #1 chk("wr_ready", cmd_ready, 1);
    for (int k = 1; k <= 8; k++) begin
      nxt();
      idle();
      chk($sformatf("wr_ms3_k%0d", k), module_select[3], (k <= 4) ? 7 : 20);
      chk($sformatf("wr_busy3_k%0d", k), slot_busy[3], (k <= 6) ? 1 : 0);
      chk($sformatf("wr_done3_k%0d", k), slot_done[3], (k == 7) ? 1 : 0);
    end
    // read route len=1, second command to the same module stalls until done
    send(1, 19, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      nxt();
      idle();
      chk($sformatf("rd_ss0_k%0d", k), slot_select[0], (k == 1) ? 19 : 20);
      chk($sformatf("rd_done0_k%0d", k), module_done[0], (k == 4) ? 1 : 0);
      if (k >= 2) begin
        send(1, 4, 0, 2);
        #1 chk($sformatf("rd_ready_k%0d", k), cmd_ready, (k == 4) ? 1 : 0);
      end
    end
    nxt();
    idle();
    chk("rd2_ss0", slot_select[0], 4);
    chk("rd2_busy0", module_busy[0], 1);
    repeat (6) nxt();
    chk("rd2_idle", module_busy[0], 0);
    // illegal commands drain with an error pulse and no state change
    for (int n = 0; n < 3; n++) begin
      if (n == 0) send(0, 7, 20, 4);
      else if (n == 1) send(0, 7, 3, 0);
      else send(0, 21, 3, 4);
      #1 chk($sformatf("ill%0d_ready", n), cmd_ready, 1);
      nxt();
      idle();
      chk($sformatf("ill%0d_err", n), cmd_err, 1);
      chk($sformatf("ill%0d_busy", n), {slot_busy, module_busy}, 0);
      chk($sformatf("ill%0d_ms", n), module_select, null_v);
      nxt();
      chk($sformatf("ill%0d_err_off", n), cmd_err, 0);
    end
    // abort mid-burst
    send(0, 2, 3, 10);
    nxt(); idle();
    chk("ab_ms3_k1", module_select[3], 2);
    nxt();
    abort_valid = 1'b1; abort_dir = 1'b0; abort_dst = 3;
    nxt(); idle();
    chk("ab_ms3_k3", module_select[3], 20);
    chk("ab_busy_k3", slot_busy[3], 1);
    nxt();
    chk("ab_done_k4", slot_done[3], 0);
    nxt();
    chk("ab_done_k5", slot_done[3], 1);
    chk("ab_busy_k5", slot_busy[3], 0);
    nxt();
    chk("ab_done_k6", slot_done[3], 0);
    // same-cycle abort and command to one destination: command stalls
    send(0, 1, 3, 2);
    abort_valid = 1'b1; abort_dir = 1'b0; abort_dst = 3;
    #1 chk("ab_same_ready", cmd_ready, 0);
    nxt(); idle();
    chk("ab_same_busy", slot_busy[3], 0);
    // abort and command to different destinations both take effect
    send(0, 1, 5, 10);
    nxt(); idle();
    nxt();
    send(0, 8, 6, 2);
    abort_valid = 1'b1; abort_dir = 1'b0; abort_dst = 5;
    #1 chk("ab_diff_ready", cmd_ready, 1);
    nxt(); idle();
    chk("ab_diff_ms5", module_select[5], 20);
    chk("ab_diff_ms6", module_select[6], 8);
    repeat (6) nxt();
    chk("ab_diff_idle", slot_busy, 0);
    // broadcast: slots 0,1,2 from module 5, then module 5 reads slot 9
    for (int k = 0; k <= 10; k++) begin
      if (k <= 2) send(0, 5, 5'(k), 3);
      else if (k == 3) send(1, 9, 5, 3);
      else idle();
      if (k >= 1) begin
        for (int j = 0; j < 3; j++) begin
          chk($sformatf("bc_ms%0d_k%0d", j, k), module_select[j], (k >= j + 1 && k <= j + 3) ? 5 : 20);
          chk($sformatf("bc_done%0d_k%0d", j, k), slot_done[j], (k == j + 6) ? 1 : 0);
        end
        chk($sformatf("bc_ss5_k%0d", k), slot_select[5], (k >= 4 && k <= 6) ? 9 : 20);
        chk($sformatf("bc_mdone5_k%0d", k), module_done[5], (k == 9) ? 1 : 0);
      end
      nxt();
    end
    idle();
    // asynchronous reset in the middle of a burst
    send(0, 7, 3, 10);
    nxt(); idle();
    nxt();
    chk("mr_ms3_active", module_select[3], 7);
    #2 rst = 1'b1;
    #1 chk("mr_ms3_null", module_select[3], 20);
    chk("mr_busy", slot_busy[3], 0);
    nxt();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      nxt();
      chk($sformatf("mr_nodone_k%0d", k), slot_done, 0);
      chk($sformatf("mr_ms_k%0d", k), module_select, null_v);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/intc_route_ctrl.md
Name: intc_route_ctrl

Overview:
- Control stage directly upstream of the 32-entry buffer interconnect. It accepts route commands from the scheduler and keeps one route FSM per destination.
- It drives the interconnect's module_select (per slot) and slot_select (per module) vectors for a programmed number of beats, then parks each selector on the zero-padded null input.
- It reports completion once the last beat has cleared the interconnect's 2-cycle pipeline.

Parameters:
- SLOT_NUM, 20, number of buffer RAM slots (write destinations).
- MODULE_NUM, 20, number of arithmetic modules (read destinations).
- LEN_W, 16, width of the burst-length field.
- ROUTE_LAT, 2, interconnect select-to-output latency in cycles (select FIFO plus one mux stage).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted this cycle when valid and ready are both high.
- cmd_dir  in  1  0 = write route (module→slot, dst is a slot); 1 = read route (slot→module, dst is a module).
- cmd_src  in  5  source index.
- cmd_dst  in  5  destination index.
- cmd_len  in  LEN_W  burst length in beats.
- abort_valid  in  1  abort request.
- abort_dir  in  1  abort target direction.
- abort_dst  in  5  abort target destination.
- module_select  out  [SLOT_NUM][$clog2(MODULE_NUM)]  per-slot source module.
- slot_select  out  [MODULE_NUM][$clog2(SLOT_NUM)]  per-module source slot.
- slot_busy  out  SLOT_NUM  slot route not IDLE.
- module_busy  out  MODULE_NUM  module route not IDLE.
- slot_done  out  SLOT_NUM  one-cycle completion pulse per slot.
- module_done  out  MODULE_NUM  one-cycle completion pulse per module.
- cmd_err  out  1  one-cycle pulse on an illegal command.

Behaviour:
- Null codes: MODULE_NUM for module_select and SLOT_NUM for slot_select. Each selects the interconnect's zero-padded input, so RAM wren=0 and module data=0 while parked.
- Reset (async, any time, including mid-burst): all selects go to null; busy, done and err go to 0; all FSMs go to IDLE; counters clear. The first cmd can be accepted on the first cycle after rst deasserts.
- cmd_ready is combinational:
  - high when the addressed destination is IDLE and no abort_valid hits the same dir/dst this cycle;
  - also high for illegal commands, so that they drain.
- Illegal command: dst out of range for dir, src out of range, or cmd_len=0. It is accepted, cmd_err pulses 1 cycle later, and no state changes.
- Per-destination FSM:
  - IDLE → ACTIVE on legal accept at cycle T. From T+1 the select register holds cmd_src, busy=1, and the beat counter = cmd_len.
  - ACTIVE: the counter decrements every cycle. When counter==1, select → null next cycle and the FSM goes to DRAIN with drain counter = ROUTE_LAT. The select is therefore held exactly cmd_len cycles (T+1 … T+cmd_len).
  - DRAIN: decrement the drain counter. When it reaches 1, go to IDLE next cycle with a done pulse in that same cycle.
  - Done rises at T+cmd_len+ROUTE_LAT+1, aligned with the last beat leaving the interconnect. busy falls in the same cycle.
- Abort:
  - ACTIVE: select → null next cycle, then DRAIN (full ROUTE_LAT), then done as normal.
  - DRAIN: ignored.
  - IDLE: ignored, no done.
  - Abort and cmd to the same dst in the same cycle: abort wins and the cmd is stalled. Abort and cmd to different dsts: both take effect.
- Broadcast (multiple destinations selecting the same src) is legal and is not checked.
- Several done pulses may fire in the same cycle.
- Selects, busy, done and err are all registered outputs; there are no combinational paths from inputs to these outputs.

Decomposition:
- FHE_ALU_PKG additions:
  - constant ROUTE_LAT = 2;
  - typedef route_cmd_t (dir, src, dst, len);
  - enum route_state_t {R_IDLE, R_ACTIVE, R_DRAIN}.
- Sub-module intc_route_fsm (params SEL_W, NULL_CODE, LEN_W), generated SLOT_NUM + MODULE_NUM times.
  - Inputs: load/src/len, abort.
  - Outputs: sel/busy/done.
- The top level keeps decode, legality check, ready and the err register.

Test Plan:
- Reset → all module_select=20, all slot_select=20, busy/done/err=0. Reassert rst mid-burst (slot 3 ACTIVE) → select 20 immediately, no done pulse.
- Write cmd dir=0 src=7 dst=3 len=4, accepted at T → module_select[3]=7 during T+1..T+4, =20 at T+5; slot_done[3] at T+7; slot_busy[3] high T+1..T+6.
- Read cmd dir=1 src=19 dst=0 len=1 at T → slot_select[0]=19 at T+1 only; module_done[0] at T+4. A second cmd to dst 0 at T+2 has cmd_ready=0 until T+4, then is accepted.
- Illegal cmds (dst=20 with dir=0, len=0, src=21) → cmd_ready=1, cmd_err pulse next cycle, no select or busy change.
- Abort dst 3 at T+2 of a len=10 write → select null at T+3, slot_done[3] at T+5. Same-cycle cmd+abort to dst 3 → cmd stalled (ready=0).
- Broadcast: slots 0,1,2 all src=5 len=3 on consecutive cycles plus read module 5 from slot 9 → independent timing per destination; slot_done pulses one cycle apart.
